// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------
// y86_pkg : shared Y86-64 codes and the W pipeline-register type
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

package y86_pkg;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_RSP  = 4'h4;

  typedef struct packed {
    logic        valid;
    logic [3:0]  icode;
    stat_e       stat;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [63:0] valE;
    logic [63:0] valM;
  } wreg_t;

  localparam wreg_t W_BUBBLE = '{
    valid: 1'b0, icode: I_NOP, stat: STAT_AOK,
    dstE: REG_NONE, dstM: REG_NONE, valE: 64'd0, valM: 64'd0
  };

  // A data-memory fault overrides whatever status the memory stage reported.
  function automatic stat_e eff_stat(logic [2:0] s, logic dmem_err);
    return dmem_err ? STAT_ADR : stat_e'(s);
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_15x64.sv
// ---------------------------------------------------------------
// regfile_15x64 : 15x64 register file, 2 async reads, 2 writes (M wins)
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

module regfile_15x64 #(
  parameter int NREGS = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  raddr_a_i,
  input  logic [3:0]  raddr_b_i,
  output logic [63:0] rdata_a_o,
  output logic [63:0] rdata_b_o,
  input  logic        we_e_i,
  input  logic [3:0]  waddr_e_i,
  input  logic [63:0] wdata_e_i,
  input  logic        we_m_i,
  input  logic [3:0]  waddr_m_i,
  input  logic [63:0] wdata_m_i
);

  logic [63:0] regs_q [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (we_m_i && waddr_m_i == 4'(i))      regs_q[i] <= wdata_m_i;
        else if (we_e_i && waddr_e_i == 4'(i)) regs_q[i] <= wdata_e_i;
      end
    end
  end

  // Address F (and anything beyond NREGS) falls through to zero.
  always_comb begin
    rdata_a_o = '0;
    rdata_b_o = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (raddr_a_i == 4'(i)) rdata_a_o = regs_q[i];
      if (raddr_b_i == 4'(i)) rdata_b_o = regs_q[i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/writeback_stage.sv
// ---------------------------------------------------------------
// writeback_stage : M/W register, status machine, bypassed reads, retire count
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

module writeback_stage
  import y86_pkg::*;
#(
  parameter int NREGS    = 15,
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          m_icode,
  input  logic [2:0]          m_stat,
  input  logic                m_valid,
  input  logic [63:0]         m_valE,
  input  logic [63:0]         m_valM,
  input  logic [3:0]          m_dstE,
  input  logic [3:0]          m_dstM,
  input  logic                dmem_error,
  input  logic                w_stall,
  input  logic                w_bubble,
  input  logic [3:0]          srcA,
  input  logic [3:0]          srcB,
  output logic [63:0]         rd_valA,
  output logic [63:0]         rd_valB,
  output logic [3:0]          W_dstE,
  output logic [3:0]          W_dstM,
  output logic [63:0]         W_valE,
  output logic [63:0]         W_valM,
  output logic [2:0]          stat,
  output logic                halted,
  output logic [RETIRE_W-1:0] retire_count
);

  wreg_t               w_q, w_d;
  logic                committed_q, committed_d;
  logic [RETIRE_W-1:0] retire_q, retire_d;
  logic                w_pending;
  logic [63:0]         rf_a, rf_b;
  logic                unused_icode;

  // Pending = valid, healthy, and not yet written; drives both commit and bypass.
  assign w_pending = w_q.valid && (w_q.stat == STAT_AOK) && !committed_q;

  always_comb begin
    w_d         = w_q;
    committed_d = committed_q | w_pending;
    retire_d    = retire_q + RETIRE_W'(w_pending);
    if (w_q.stat == STAT_AOK) begin
      if (w_bubble) begin
        w_d         = W_BUBBLE;
        committed_d = 1'b0;
      end else if (!w_stall) begin
        w_d = '{valid: m_valid, icode: m_icode, stat: eff_stat(m_stat, dmem_error),
                dstE: m_dstE, dstM: m_dstM, valE: m_valE, valM: m_valM};
        committed_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q         <= W_BUBBLE;
      committed_q <= 1'b0;
      retire_q    <= '0;
    end else begin
      w_q         <= w_d;
      committed_q <= committed_d;
      retire_q    <= retire_d;
    end
  end

  regfile_15x64 #(.NREGS(NREGS)) u_rf (
    .clk       (clk),
    .rst       (rst),
    .raddr_a_i (srcA),
    .raddr_b_i (srcB),
    .rdata_a_o (rf_a),
    .rdata_b_o (rf_b),
    .we_e_i    (w_pending && w_q.dstE != REG_NONE),
    .waddr_e_i (w_q.dstE),
    .wdata_e_i (w_q.valE),
    .we_m_i    (w_pending && w_q.dstM != REG_NONE),
    .waddr_m_i (w_q.dstM),
    .wdata_m_i (w_q.valM)
  );

  always_comb begin
    rd_valA = rf_a;
    if (srcA == REG_NONE)                    rd_valA = '0;
    else if (w_pending && srcA == w_q.dstM)  rd_valA = w_q.valM;
    else if (w_pending && srcA == w_q.dstE)  rd_valA = w_q.valE;

    rd_valB = rf_b;
    if (srcB == REG_NONE)                    rd_valB = '0;
    else if (w_pending && srcB == w_q.dstM)  rd_valB = w_q.valM;
    else if (w_pending && srcB == w_q.dstE)  rd_valB = w_q.valE;
  end

  assign W_dstE       = w_q.dstE;
  assign W_dstM       = w_q.dstM;
  assign W_valE       = w_q.valE;
  assign W_valM       = w_q.valM;
  assign stat         = w_q.stat;
  assign halted       = (w_q.stat != STAT_AOK);
  assign retire_count = retire_q;
  assign unused_icode = ^w_q.icode;

endmodule

`default_nettype wire

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final stage of the pipelined Y86-64 core, directly downstream of the data-memory stage.
- Contains the M/W pipeline register, the 15-entry 64-bit register file, the processor status machine and a retired-instruction counter.
- Captures valE/valM/dst/stat results from memory and commits them to the register file.
- Provides two bypassed read ports to decode.

Parameters:
NREGS, 15, number of architectural registers (IDs 0..14; ID 4'hF means "no register").
RETIRE_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
m_icode  in  4  icode of the instruction leaving the memory stage.
m_stat  in  3  stage status: AOK=1, HLT=2, ADR=3, INS=4.
m_valid  in  1  1 = the memory stage holds a real instruction; 0 = bubble.
m_valE  in  64  ALU result.
m_valM  in  64  data-memory read value.
m_dstE  in  4  destination register for valE.
m_dstM  in  4  destination register for valM.
dmem_error  in  1  data-memory address error from the memory stage.
w_stall  in  1  hold the W register.
w_bubble  in  1  load a bubble into the W register.
srcA  in  4  read port A register ID.
srcB  in  4  read port B register ID.
rd_valA  out  64  bypassed read data for srcA.
rd_valB  out  64  bypassed read data for srcB.
W_dstE, W_dstM  out  4 each  current W-register destinations (for hazard logic).
W_valE, W_valM  out  64 each  current W-register values.
stat  out  3  processor status, equal to W_stat.
halted  out  1  high when stat != AOK.
retire_count  out  RETIRE_W  number of instructions committed with AOK status.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - All register-file entries = 0.
  - W register becomes a bubble: W_valid=0, W_icode=4'h1 (nop), W_stat=AOK, W_dstE=W_dstM=4'hF, W_valE=W_valM=0.
  - retire_count=0, halted=0.
- Effective incoming status: m_stat_eff = ADR if dmem_error=1, otherwise m_stat.
- Status machine: RUN (W_stat=AOK); HLT, ADR and INS are absorbing error states.
  - The machine leaves RUN only when an instruction with non-AOK m_stat_eff is captured into W.
  - The only way out of HLT, ADR or INS is rst.
- W register update at each posedge, in priority order:
  1. Frozen: W_stat != AOK -> hold.
  2. w_bubble=1 -> load a bubble (bubble wins over w_stall).
  3. w_stall=1 -> hold.
  4. Otherwise capture m_* with m_stat_eff.
- Register-file write at each posedge, using the W contents present before the edge:
  - Enabled only when W_valid=1 and W_stat=AOK.
  - Write W_valE to W_dstE if W_dstE != F.
  - Write W_valM to W_dstM if W_dstM != F.
  - If W_dstE == W_dstM, valM wins.
  - Register ID F is never written.
  - An instruction held in W by w_stall is written exactly once (on the first edge only).
  - Implementation: a W_committed flag, cleared on each capture and set after the write.
- retire_count increments by 1 on the edge where a W instruction commits (same condition as the register-file write). It wraps modulo 2^RETIRE_W.
- Read ports are combinational, with no added latency. Per port, in priority order:
  1. src = F -> 0.
  2. src == W_dstM, with W_valid and AOK and not yet committed -> W_valM.
  3. src == W_dstE, with the same qualifiers -> W_valE.
  4. Otherwise the register-file entry.
- Latency: a result entering W on edge N is visible at rd_valX via bypass in cycle N. It is architecturally in the register file after edge N+1.
- A halting or faulting instruction performs no register write and is not counted.
- All older instructions have already committed before it, in program order.

Decomposition:
- Shared package y86_pkg holds:
  - Stat codes AOK/HLT/ADR/INS.
  - icode constants (NOP=1, HALT=0, RRMOVQ=2, IRMOVQ=3, RMMOVQ=4, MRMOVQ=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSHQ=A, POPQ=B).
  - REG_NONE=4'hF and REG_RSP=4'h4.
- One sub-module: regfile_15x64. It provides two async read ports and two posedge write ports, with port M taking priority on the same address, plus async reset. The stage logic (W register, status, bypass, counter) lives in writeback_stage.

Test Plan:
- Reset mid-run:
  - Stimulus: load R3=0x55, then assert rst asynchronously between edges.
  - Response: rd_valA(src=3)=0 immediately; stat=AOK; retire_count=0; W_dstE=F.
- Single commit with bypass:
  - Stimulus: capture m_valid=1, m_dstE=2, m_valE=0x1234, m_stat=AOK.
  - Response: the same cycle, rd_valA(src=2)=0x1234 via bypass. After the next edge, R2=0x1234 and retire_count=1.
- Same destination on both write ports:
  - Stimulus: popq-style instruction with m_dstE=4, m_valE=0x100, m_dstM=4, m_valM=0xABCD.
  - Response: R4=0xABCD; rd_valB(src=4) reads 0xABCD during the W cycle.
- Memory error freezes the pipeline:
  - Stimulus: capture mrmovq with dmem_error=1, m_dstM=1, m_valM=0x99.
  - Response: stat=ADR and halted=1; R1 unchanged; retire_count unchanged. Later m_* inputs and w_bubble are ignored until rst.
- Stall and bubble control:
  - Stimulus: hold an AOK instruction (dstE=5, valE=7) with w_stall=1 for 3 edges, then assert w_stall=1 and w_bubble=1 together.
  - Response: R5 written once; retire_count +1 (not +3); W becomes a bubble with W_dstE=F.
- Halt:
  - Stimulus: capture m_icode=0 (halt) with m_stat=HLT, following 2 committed AOK instructions.
  - Response: stat=HLT, halted=1, retire_count=2, and no further register writes.
